// File: rtl/led_matrix_scan_rx.sv
// Pixel-code receiver for the 16x8 bicolour LED matrix.
// It double-buffers one game frame at a time and scans the displayed frame out row by row.
module led_matrix_scan_rx #(
    parameter int ROW_DIV   = 2000,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  pix_code,
    input  logic        frame_sync,
    output logic [15:0] row_sel,
    output logic [7:0]  col_red,
    output logic [7:0]  col_grn,
    output logic        frame_done,
    output logic        ovf
);

    localparam int DIV_W = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       row_q, row_d;
    logic             pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cap_r_q [16];
    logic [7:0]       cap_r_d [16];
    logic [7:0]       cap_g_q [16];
    logic [7:0]       cap_g_d [16];
    logic [7:0]       disp_r_q [16];
    logic [7:0]       disp_r_d [16];
    logic [7:0]       disp_g_q [16];
    logic [7:0]       disp_g_d [16];
    logic [15:0]      row_sel_q, row_sel_d;
    logic [7:0]       col_red_q, col_red_d;
    logic [7:0]       col_grn_q, col_grn_d;

    logic       div_wrap;
    logic       swap;
    logic [3:0] pix_y;
    logic [2:0] pix_x;

    assign pix_y = pix_code[6:3];
    assign pix_x = pix_code[2:0];

    always_comb begin
        div_wrap  = (div_q == DIV_W'(ROW_DIV - 1));
        swap      = div_wrap && (row_q == 4'd15) && pending_q;

        div_d     = div_q + DIV_W'(1);
        row_d     = row_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        cap_r_d   = cap_r_q;
        cap_g_d   = cap_g_q;
        disp_r_d  = disp_r_q;
        disp_g_d  = disp_g_q;

        if (div_wrap) begin
            div_d = '0;
            row_d = row_q + 4'd1;
        end

        // A pending frame blocks both capture and new frame_sync pulses, including in the swap cycle.
        if (frame_sync && pending_q) begin
            ovf_d = 1'b1;
        end

        if (swap) begin
            disp_r_d  = cap_r_q;
            disp_g_d  = cap_g_q;
            cap_r_d   = '{default: '0};
            cap_g_d   = '{default: '0};
            pending_d = 1'b0;
        end else if (!pending_q) begin
            if (pix_code[9]) cap_r_d[pix_y][pix_x] = 1'b1;
            if (pix_code[8]) cap_g_d[pix_y][pix_x] = 1'b1;
            if (frame_sync)  pending_d = 1'b1;
        end

        row_sel_d = '0;
        col_red_d = '0;
        col_grn_d = '0;
        if (div_q >= DIV_W'(BLANK_CYC)) begin
            row_sel_d = 16'd1 << row_q;
            col_red_d = disp_r_q[row_q];
            col_grn_d = disp_g_q[row_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q     <= '0;
            row_q     <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            cap_r_q   <= '{default: '0};
            cap_g_q   <= '{default: '0};
            disp_r_q  <= '{default: '0};
            disp_g_q  <= '{default: '0};
            row_sel_q <= '0;
            col_red_q <= '0;
            col_grn_q <= '0;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            cap_r_q   <= cap_r_d;
            cap_g_q   <= cap_g_d;
            disp_r_q  <= disp_r_d;
            disp_g_q  <= disp_g_d;
            row_sel_q <= row_sel_d;
            col_red_q <= col_red_d;
            col_grn_q <= col_grn_d;
        end
    end

    assign row_sel    = row_sel_q;
    assign col_red    = col_red_q;
    assign col_grn    = col_grn_q;
    assign frame_done = swap;
    assign ovf        = ovf_q;

endmodule
